// File: rtl/fc_argmax.sv
// fc_argmax: streaming arg-max over the NUM_CLASSES output nodes of a
// fully-connected layer. After an enable, nodes are accepted one per
// handshake. The winning index/value is published with a one-cycle
// 'finished' pulse the cycle after the last node is accepted.
//
// Optional feature: define FC_ARGMAX_RELU_EN to clamp negative nodes to
// zero before they are compared and before they are captured.
module fc_argmax #(
    parameter int NUM_CLASSES = 10,
    parameter int DATA_W      = 16,
    parameter int IDX_W       = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [IDX_W-1:0]  class_idx,
    output logic [DATA_W-1:0] max_score,
    output logic              finished
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCEPT = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);
    localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);
    localparam logic [IDX_W-1:0] ZERO_IDX = {IDX_W{1'b0}};
    localparam logic [DATA_W-1:0] ZERO_DAT = {DATA_W{1'b0}};

    // Node conditioning applied before compare and capture.
    function automatic logic signed [DATA_W-1:0] relu_clamp(
        input logic signed [DATA_W-1:0] v
    );
`ifdef FC_ARGMAX_RELU_EN
        if (v[DATA_W-1]) begin
            return $signed(ZERO_DAT);
        end else begin
            return v;
        end
`else
        return v;
`endif
    endfunction

    state_t                     state_q,     state_d;
    logic [IDX_W-1:0]           cnt_q,       cnt_d;
    logic signed [DATA_W-1:0]   run_max_q,   run_max_d;
    logic [IDX_W-1:0]           run_idx_q,   run_idx_d;
    logic [IDX_W-1:0]           class_idx_q, class_idx_d;
    logic [DATA_W-1:0]          max_score_q, max_score_d;
    logic                       finished_q,  finished_d;
    logic                       in_ready_q,  in_ready_d;

    logic signed [DATA_W-1:0]   beat_val_s;
    logic                       xfer_s;
    logic                       take_s;
    logic signed [DATA_W-1:0]   win_max_s;
    logic [IDX_W-1:0]           win_idx_s;

    // Candidate winner if the current node is accepted (first beat always wins,
    // later beats only on a strictly greater signed value so ties keep the earlier index).
    always_comb begin
        beat_val_s = relu_clamp($signed(in_data));
        xfer_s     = in_ready_q & in_valid;
        if (cnt_q == ZERO_IDX) begin
            take_s = 1'b1;
        end else begin
            take_s = (beat_val_s > run_max_q);
        end
        if (take_s) begin
            win_max_s = beat_val_s;
            win_idx_s = cnt_q;
        end else begin
            win_max_s = run_max_q;
            win_idx_s = run_idx_q;
        end
    end

    // Next-state and next-output logic of the IDLE/ACCEPT/DONE controller.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        run_max_d   = run_max_q;
        run_idx_d   = run_idx_q;
        class_idx_d = class_idx_q;
        max_score_d = max_score_q;
        finished_d  = 1'b0;
        in_ready_d  = in_ready_q;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d    = S_ACCEPT;
                    cnt_d      = ZERO_IDX;
                    in_ready_d = 1'b1;
                end else begin
                    state_d    = S_IDLE;
                    in_ready_d = 1'b0;
                end
            end
            S_ACCEPT: begin
                if (xfer_s) begin
                    run_max_d = win_max_s;
                    run_idx_d = win_idx_s;
                    if (cnt_q == LAST_IDX) begin
                        state_d     = S_DONE;
                        cnt_d       = ZERO_IDX;
                        class_idx_d = win_idx_s;
                        max_score_d = win_max_s;
                        finished_d  = 1'b1;
                        in_ready_d  = 1'b0;
                    end else begin
                        cnt_d      = cnt_q + ONE_IDX;
                        in_ready_d = 1'b1;
                    end
                end else begin
                    // Stall: everything holds, no timeout.
                    in_ready_d = 1'b1;
                end
            end
            S_DONE: begin
                // Enable is deliberately not looked at here.
                state_d    = S_IDLE;
                in_ready_d = 1'b0;
            end
            default: begin
                state_d    = S_IDLE;
                cnt_d      = ZERO_IDX;
                in_ready_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs, asynchronously cleared by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= ZERO_IDX;
            run_max_q   <= $signed(ZERO_DAT);
            run_idx_q   <= ZERO_IDX;
            class_idx_q <= ZERO_IDX;
            max_score_q <= ZERO_DAT;
            finished_q  <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            run_max_q   <= run_max_d;
            run_idx_q   <= run_idx_d;
            class_idx_q <= class_idx_d;
            max_score_q <= max_score_d;
            finished_q  <= finished_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign class_idx = class_idx_q;
    assign max_score = max_score_q;
    assign finished  = finished_q;

endmodule

// File: tb/tb_fc_argmax.sv
// Testbench for fc_argmax: directed frames, a frame-level arg-max model that
// is compared against the DUT every cycle, and literal expectations per frame.
module tb_fc_argmax;

    localparam int N = 10;

    typedef logic [15:0] frame_t [16];
    typedef logic [15:0] vec_t [N];

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic [3:0]  class_idx;
    logic [15:0] max_score;
    logic        finished;

    int checks   = 0;
    int failures = 0;
    bit run_chk  = 1'b0;

    fc_argmax #(.NUM_CLASSES(N), .DATA_W(16), .IDX_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .class_idx (class_idx),
        .max_score (max_score),
        .finished  (finished)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model ----------------
    function automatic logic signed [15:0] relu(input logic signed [15:0] v);
`ifdef FC_ARGMAX_RELU_EN
        return (v < 16'sd0) ? 16'sd0 : v;
`else
        return v;
`endif
    endfunction

    function automatic logic [15:0] frame_val(input frame_t f, input logic [3:0] nb,
                                              input logic [15:0] cur, input logic [3:0] i);
        return (i == nb) ? cur : f[i];
    endfunction

    // Index of the first maximum over beats 0..nb (beat nb is 'cur').
    function automatic logic [3:0] best_of(input frame_t f, input logic [3:0] nb,
                                           input logic [15:0] cur);
        logic [3:0] b;
        b = 4'd0;
        for (int i = 1; i < 16; i++) begin
            if (i <= int'(nb)) begin
                if (relu($signed(frame_val(f, nb, cur, 4'(i)))) >
                    relu($signed(frame_val(f, nb, cur, b))))
                    b = 4'(i);
            end
        end
        return b;
    endfunction

    int          m_mode;   // 0 idle, 1 accepting, 2 result cycle
    logic [3:0]  m_nb;
    frame_t      m_frame;
    logic [3:0]  exp_idx;
    logic [15:0] exp_max;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode  <= 0;
            m_nb    <= 4'd0;
            exp_idx <= 4'd0;
            exp_max <= 16'd0;
        end else begin
            case (m_mode)
                0: if (enable) begin m_mode <= 1; m_nb <= 4'd0; end
                1: if (in_valid) begin
                       m_frame[m_nb] <= in_data;
                       if (m_nb == 4'(N - 1)) begin
                           m_mode  <= 2;
                           exp_idx <= best_of(m_frame, m_nb, in_data);
                           exp_max <= relu($signed(frame_val(m_frame, m_nb, in_data,
                                           best_of(m_frame, m_nb, in_data))));
                       end else begin
                           m_nb <= m_nb + 4'd1;
                       end
                   end
                default: m_mode <= 0;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (run_chk && rst_n === 1'b1) begin
            chk("cyc_in_ready",  32'(in_ready),  32'(m_mode == 1));
            chk("cyc_finished",  32'(finished),  32'(m_mode == 2));
            chk("cyc_class_idx", 32'(class_idx), 32'(exp_idx));
            chk("cyc_max_score", 32'(max_score), 32'(exp_max));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic start_frame();
        @(posedge clk); #1 enable = 1'b1;
        @(posedge clk); #1 enable = 1'b0;
    endtask

    task automatic send_frame(input vec_t v, input bit gaps);
        for (int k = 0; k < N; k++) begin
            if (gaps) begin
                for (int g = 0; g < (k % 4); g++) begin
                    in_valid = 1'b0; in_data = 16'hDEAD;
                    @(posedge clk); #1;
                end
            end
            in_valid = 1'b1; in_data = v[k];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    // Waits at negedges for the finished pulse; returns cycles waited.
    task automatic wait_fin(input string name, output int waited);
        bit seen;
        seen   = 1'b0;
        waited = 0;
        while (!seen && waited < 20) begin
            @(negedge clk);
            if (finished === 1'b1) seen = 1'b1;
            else waited++;
        end
        chk({name, "_finished_seen"}, 32'(finished), 32'd1);
    endtask

    vec_t v;
    int   w;

    initial begin
        rst_n = 1'b0; enable = 1'b0; in_valid = 1'b0; in_data = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_finished",  32'(finished),  32'd0);
        chk("rst_class_idx", 32'(class_idx), 32'd0);
        chk("rst_max_score", 32'(max_score), 32'd0);
        rst_n = 1'b1; run_chk = 1'b1;

        // Frame 1: 0..9 scaled by 16, back-to-back.
        for (int k = 0; k < N; k++) v[k] = 16'(k * 16);
        start_frame();
        send_frame(v, 1'b0);
        wait_fin("t1", w);
        chk("t1_latency",   32'(w),         32'd0);
        chk("t1_class_idx", 32'(class_idx), 32'd9);
        chk("t1_max_score", 32'(max_score), 32'h0090);

        // Frame 2: tie at index 3 must lose to index 1; gaps of 0..3 cycles.
        v = '{16'd5, 16'd100, 16'd3, 16'd100, 16'd4, 16'd6, 16'd7, 16'd8, 16'd9, 16'd2};
        start_frame();
        send_frame(v, 1'b1);
        wait_fin("t2", w);
        chk("t2_class_idx", 32'(class_idx), 32'd1);
        chk("t2_max_score", 32'(max_score), 32'd100);

        // Frame 3: all negative.
        for (int k = 0; k < N; k++) v[k] = 16'hFFF0 + 16'(k);
        start_frame();
        send_frame(v, 1'b0);
        wait_fin("t3", w);
`ifdef FC_ARGMAX_RELU_EN
        chk("t3_class_idx", 32'(class_idx), 32'd0);
        chk("t3_max_score", 32'(max_score), 32'h0000);
`else
        chk("t3_class_idx", 32'(class_idx), 32'd9);
        chk("t3_max_score", 32'(max_score), 32'hFFF9);
`endif

        // Frame 4: reset after beat 4, then a fresh frame with the max at index 2.
        start_frame();
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; in_data = 16'h7000 + 16'(k);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t4_rst_finished",  32'(finished),  32'd0);
        chk("t4_rst_class_idx", 32'(class_idx), 32'd0);
        chk("t4_rst_in_ready",  32'(in_ready),  32'd0);
        repeat (3) @(negedge clk) chk("t4_no_fin", 32'(finished), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1; enable = 1'b1;
        @(posedge clk); #1 enable = 1'b0;
        v = '{16'd1, 16'd2, 16'd50, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9};
        send_frame(v, 1'b0);
        wait_fin("t4", w);
        chk("t4_latency",   32'(w),         32'd0);
        chk("t4_class_idx", 32'(class_idx), 32'd2);
        chk("t4_max_score", 32'(max_score), 32'd50);

        // Frames 5/6: enable held high, junk offered while not ready.
        @(posedge clk); #1;                 // DONE -> IDLE
        enable = 1'b1; in_valid = 1'b1; in_data = 16'h7FFF;
        @(negedge clk);
        chk("t5_idle_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;                 // IDLE -> ACCEPT
        v = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd500, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9};
        send_frame(v, 1'b0);
        in_valid = 1'b1; in_data = 16'h7FFF;  // offered during DONE
        @(negedge clk);
        chk("t5_fin",       32'(finished),  32'd1);
        chk("t5_class_idx", 32'(class_idx), 32'd4);
        chk("t5_max_score", 32'(max_score), 32'd500);
        chk("t5_done_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1 in_valid = 1'b0;   // IDLE, valid toggled low
        @(negedge clk);
        chk("t5_idle2_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;                 // ACCEPT again via held enable
        chk("t6_hold_idx", 32'(class_idx), 32'd4);
        v = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd300, 16'd8, 16'd9};
        send_frame(v, 1'b0);
        enable = 1'b0;
        wait_fin("t6", w);
        chk("t6_latency",   32'(w),         32'd0);
        chk("t6_class_idx", 32'(class_idx), 32'd7);
        chk("t6_max_score", 32'(max_score), 32'h012C);

        repeat (4) @(posedge clk);
        #1;
        chk("end_ready", 32'(in_ready), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fc_argmax.md
FC_ARGMAX -- requirements
Module: fc_argmax

Interface
REQ-001 Parameter NUM_CLASSES, default 10, number of FC output nodes scored per frame (legal 2..16).
REQ-002 Parameter DATA_W, default 16, width of one signed fixed-point output node.
REQ-003 Parameter IDX_W, default 4, class index width, SHALL equal ceil(log2(NUM_CLASSES)).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 enable  input  1  start request; sampled only in IDLE.
REQ-007 in_valid  input  1  an output node is present on in_data.
REQ-008 in_data  input  DATA_W  one FC output node, two's complement.
REQ-009 in_ready  output  1  block accepts a node this cycle.
REQ-010 class_idx  output  IDX_W  index (0-based, arrival order) of the winning node.
REQ-011 max_score  output  DATA_W  value of the winning node.
REQ-012 finished  output  1  one-cycle pulse, frame result valid.

Function
REQ-013 FSM states IDLE, ACCEPT, DONE; reset state IDLE.
REQ-014 IDLE: in_ready=0; enable=1 -> ACCEPT next cycle, beat counter cleared to 0.
REQ-015 ACCEPT: in_ready=1; a beat transfers when in_valid=1 and in_ready=1; counter increments per transfer.
REQ-016 in_valid=0 in ACCEPT stalls; counter and running max held, no timeout.
REQ-017 First beat of a frame loads the running max and index unconditionally.
REQ-018 Later beats: signed compare; update only when in_data > running max (strict); ties keep the earlier index.
REQ-019 On the transfer with counter = NUM_CLASSES-1 -> DONE next cycle; class_idx and max_score registered from the final running max, including that last beat.
REQ-020 DONE: finished=1 for exactly one cycle, in_ready=0, then -> IDLE unconditionally.
REQ-021 Latency: finished asserts the cycle after the last accepted beat.
REQ-022 class_idx/max_score hold their values until the next DONE; they do not change during ACCEPT.
REQ-023 enable during ACCEPT or DONE is ignored; enable in the DONE->IDLE cycle is not captured.
REQ-024 Beats offered while in_ready=0 are not consumed and do not affect state.
REQ-025 No arithmetic other than comparison; no overflow possible.

Reset
REQ-026 rst_n=0 forces, asynchronously: state IDLE, counter 0, running max 0, class_idx 0, max_score 0, finished 0, in_ready 0.
REQ-027 Reset mid-frame discards the partial frame; no finished pulse; the next frame requires a new enable.
REQ-028 First enable is honoured in the first rising edge after rst_n deasserts.

Configuration
REQ-029 Macro FC_ARGMAX_RELU_EN: when defined, each in_data value SHALL be clamped to 0 if negative before compare and before capture into max_score.
REQ-030 With FC_ARGMAX_RELU_EN defined, an all-negative frame yields class_idx 0, max_score 0 (ties keep the earliest).
REQ-031 Without FC_ARGMAX_RELU_EN, raw signed values are compared and captured unmodified.

Verification
REQ-032 Reset, enable, 10 beats back-to-back with values 0..9 scaled x16 -> finished 1 cycle after beat 9, class_idx 9, max_score 0x0090.
REQ-033 Beats {5,100,3,100,...,2} with in_valid gaps of 0-3 cycles -> class_idx 1, max_score 100; tie index 3 not chosen.
REQ-034 All-negative frame 0xFFF0..0xFFF9 (beat k = 0xFFF0+k) -> without macro class_idx 9, max_score 0xFFF9; with macro class_idx 0, max_score 0.
REQ-035 rst_n low after beat 4 then new enable and frame with max at index 2 -> no finished pulse for the aborted frame, class_idx 2 after second frame.
REQ-036 enable held high across two frames, in_valid toggled in IDLE/DONE -> in_ready 0 there, no beats consumed, each frame reports its own result and previous outputs hold until the new finished.
